// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-7-segment display driver.
// Segment codes are active-low, ordered a..g from bit 6 down to bit 0.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  // Smallest value that no longer fits in the given number of decimal digits.
  function automatic logic [31:0] pow10(input int digits);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < digits; i++) begin
      p = p * 32'd10;
    end
    return p;
  endfunction

endpackage

// File: rtl/seg7_encoder.sv
// One BCD digit to active-low 7-segment pattern; a set blank flag or a
// non-decimal nibble turns every segment off.
module seg7_encoder
  import bcd_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bcd_display_seq.sv
// Serial double-dabble converter feeding DIGITS registered 7-segment displays.
// Optional build macro LEADING_ZERO_BLANK_EN blanks zero digits above the most significant non-zero one.
module bcd_display_seq
  import bcd_pkg::*;
#(
  parameter int N      = 10,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N-1:0]          bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   seg_out
);

  localparam int          BCD_W = 4 * DIGITS;
  localparam int          CNT_W = $clog2(N + 1);
  localparam logic [31:0] LIMIT = pow10(DIGITS);

  state_t              state_reg;
  logic [N-1:0]        shift_reg;
  logic [BCD_W-1:0]    bcd_reg;
  logic [BCD_W-1:0]    bcd_adj;
  logic [CNT_W-1:0]    cnt_reg;
  logic                ovf_cap_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                overflow_reg;
  logic [7*DIGITS-1:0] seg_reg;
  logic [7*DIGITS-1:0] seg_enc;
  logic [DIGITS-1:0]   blank;
  logic                ovf_next;

  assign ovf_next = (32'(bin_in) >= LIMIT);

  // Add-3 correction applied to every nibble before each shift.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5)
                                ? bcd_reg[4*gi +: 4] + 4'd3
                                : bcd_reg[4*gi +: 4];
    end
  endgenerate

`ifdef LEADING_ZERO_BLANK_EN
  logic hi_zero;
  // Walk down from the top digit; the units digit is never blanked.
  always_comb begin
    blank   = '0;
    hi_zero = 1'b1;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      hi_zero  = hi_zero & (bcd_reg[4*d +: 4] == 4'd0);
      blank[d] = hi_zero;
    end
  end
`else
  assign blank = '0;
`endif

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_enc
      seg7_encoder u_enc (
        .bcd   (bcd_reg[4*gi +: 4]),
        .blank (blank[gi]),
        .seg   (seg_enc[7*gi +: 7])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      bcd_reg      <= '0;
      cnt_reg      <= '0;
      ovf_cap_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      seg_reg      <= '1;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            shift_reg   <= bin_in;
            bcd_reg     <= '0;
            cnt_reg     <= CNT_W'(N);
            ovf_cap_reg <= ovf_next;
            busy_reg    <= 1'b1;
            state_reg   <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd_reg, shift_reg} <= {bcd_adj, shift_reg} << 1;
          cnt_reg <= cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) begin
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          seg_reg      <= ovf_cap_reg ? {DIGITS{SEG_DASH}} : seg_enc;
          overflow_reg <= ovf_cap_reg;
          done_reg     <= 1'b1;
          busy_reg     <= 1'b0;
          state_reg    <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign overflow = overflow_reg;
  assign seg_out  = seg_reg;

endmodule
